usb_serial_rx_fifo: RTL and testbench



---
 rtl/usb_serial_rx_fifo.sv | 67 ++++++
 tb/tb_usb_serial_rx_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/usb_serial_rx_fifo.sv
// usb_serial_rx_fifo: push-only byte stream to valid/ready stream buffer with level, almost-full and drop status
module usb_serial_rx_fifo #(
  parameter int ASIZE        = 10,
  parameter int AFULL_THRESH = 768
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ASIZE+1:0] level,
  output logic             almost_full,
  output logic             overflow,
  output logic [15:0]      drop_cnt
);

  logic [7:0]       mem [2**ASIZE];
  logic [ASIZE:0]   wptr, rptr, wptr_n, rptr_n, diff_n;
  logic [ASIZE+1:0] level_n;
  logic             empty, mem_full, push, drop, load, valid_n;

  // Full/empty are judged on pre-edge pointers, so a pop never frees a slot for a same-cycle push
  always_comb begin
    empty    = wptr == rptr;
    mem_full = wptr == {~rptr[ASIZE], rptr[ASIZE-1:0]};
    push     = in_valid & ~mem_full & ~clr;
    drop     = in_valid & mem_full & ~clr;
    load     = ~empty & (~out_valid | out_ready) & ~clr;
    wptr_n   = clr ? '0 : wptr + (ASIZE+1)'(push);
    rptr_n   = clr ? '0 : rptr + (ASIZE+1)'(load);
    valid_n  = clr ? 1'b0 : load | (out_valid & ~out_ready);
    diff_n   = wptr_n - rptr_n;
    level_n  = {1'b0, diff_n} + (ASIZE+2)'(valid_n);
  end

  // Unreset storage keeps the array mappable onto block RAM
  always_ff @(posedge clk) begin
    if (push) mem[wptr[ASIZE-1:0]] <= in_data;
  end

  // Pointers, output register and status all advance from the next-state values above
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr        <= '0;
      rptr        <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      level       <= '0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      out_valid   <= valid_n;
      level       <= level_n;
      almost_full <= level_n >= (ASIZE+2)'(AFULL_THRESH);
      if (load) out_data <= mem[rptr[ASIZE-1:0]];
      overflow    <= clr ? 1'b0 : overflow | drop;
      drop_cnt    <= clr ? '0 : drop_cnt + 16'(drop & ~&drop_cnt);
    end
  end

endmodule

// File: tb/tb_usb_serial_rx_fifo.sv
// tb_usb_serial_rx_fifo: directed and random stimulus against a queue-based reference model
module tb_usb_serial_rx_fifo;

  localparam int ASIZE = 4;
  localparam int DEPTH = 16;
  localparam int THR   = 12;

  logic       clk = 0, rstn = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0, out_data;
  logic       out_valid, almost_full, overflow;
  logic [5:0] level;
  logic [15:0] drop_cnt;

  int errors = 0, checks = 0;

  byte unsigned q[$];
  logic [7:0]  m_data = 0;
  bit          m_valid = 0, m_ovf = 0;
  int          m_drops = 0;

  usb_serial_rx_fifo #(.ASIZE(ASIZE), .AFULL_THRESH(THR)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  task automatic check_all(input string tag);
    int lv;
    lv = q.size() + int'(m_valid);
    chk({tag, ".valid"}, int'(out_valid), int'(m_valid));
    if (m_valid) chk({tag, ".data"}, int'(out_data), int'(m_data));
    chk({tag, ".level"}, int'(level), lv);
    chk({tag, ".afull"}, int'(almost_full), int'(lv >= THR));
    chk({tag, ".ovf"}, int'(overflow), int'(m_ovf));
    chk({tag, ".drops"}, int'(drop_cnt), m_drops);
  endtask

  // Drive one cycle of inputs (caller sits at a negedge), update the model at the edge, check after it
  task automatic step(input string tag, input bit iv, input logic [7:0] d, input bit rdy, input bit c);
    bit full, ld;
    in_valid = iv; in_data = d; out_ready = rdy; clr = c;
    @(posedge clk);
    if (c) model_reset();
    else begin
      full = q.size() == DEPTH;
      ld   = q.size() > 0 && (!m_valid || rdy);
      if (iv && full) begin
        m_ovf = 1;
        if (m_drops != 16'hFFFF) m_drops++;
      end
      if (ld) begin
        m_data  = q.pop_front();
        m_valid = 1;
      end else if (m_valid && rdy) m_valid = 0;
      if (iv && !full) q.push_back(d);
    end
    #1 check_all(tag);
    @(negedge clk);
    in_valid = 0; out_ready = 0; clr = 0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset.valid", int'(out_valid), 0);
    chk("reset.level", int'(level), 0);
    chk("reset.drops", int'(drop_cnt), 0);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);

    // latency and single pop
    step("t1.push", 1, 8'h41, 0, 0);
    step("t1.hold", 0, 0, 0, 0);
    chk("t1.data41", int'(out_data), 8'h41);
    step("t1.pop", 0, 0, 1, 0);
    chk("t1.empty", int'(level), 0);

    // fill to capacity, overflow, drain in order
    for (int i = 0; i <= 16; i++) step("t2.fill", 1, 8'(i), 0, 0);
    chk("t2.level17", int'(level), 17);
    step("t2.drop", 1, 8'hAA, 0, 0);
    chk("t2.drop1", int'(drop_cnt), 1);
    for (int i = 0; i < 18; i++) step("t2.drain", 0, 0, 1, 0);

    // streaming with pointer wrap
    step("t3.clr", 0, 0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      step("t3.stream", 1, 8'(i), 1, 0);
      chk("t3.lvl_le2", int'(level <= 2), 1);
    end
    for (int i = 0; i < 3; i++) step("t3.tail", 0, 0, 1, 0);

    // full boundary: same-cycle push dropped, next-cycle push accepted
    step("t4.clr", 0, 0, 0, 1);
    for (int i = 0; i <= 16; i++) step("t4.fill", 1, 8'(8'h20 + i), 0, 0);
    step("t4.edgeK", 1, 8'hE1, 1, 0);
    chk("t4.dropK", int'(drop_cnt), 1);
    step("t4.edgeK1", 1, 8'hE2, 0, 0);
    chk("t4.keepK1", int'(drop_cnt), 1);
    for (int i = 0; i < 18; i++) step("t4.drain", 0, 0, 1, 0);

    // drop counter saturation
    step("t5.clr", 0, 0, 0, 1);
    for (int i = 0; i <= 16; i++) step("t5.fill", 1, 8'(i), 0, 0);
    force dut.drop_cnt = 16'hFFFE;
    #1 release dut.drop_cnt;
    m_drops = 16'hFFFE;
    for (int i = 0; i < 3; i++) step("t5.sat", 1, 8'h55, 0, 0);
    chk("t5.ffff", int'(drop_cnt), 16'hFFFF);

    // clr with simultaneous push
    step("t6.clr", 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step("t6.fill", 1, 8'(i), 0, 0);
    step("t6.clrpush", 1, 8'h77, 1, 1);
    chk("t6.lvl0", int'(level), 0);

    // randomized traffic with occasional flush
    for (int i = 0; i < 600; i++)
      step("rand", $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 79) == 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) step("t6.refill", 1, 8'(i + 1), 0, 0);
    #2 rstn = 0;
    #1;
    chk("t6.arst.valid", int'(out_valid), 0);
    chk("t6.arst.data", int'(out_data), 0);
    chk("t6.arst.level", int'(level), 0);
    chk("t6.arst.afull", int'(almost_full), 0);
    chk("t6.arst.ovf", int'(overflow), 0);
    chk("t6.arst.drops", int'(drop_cnt), 0);
    model_reset();
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    step("t6.after", 1, 8'h99, 0, 0);
    step("t6.after2", 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
